compress_stream_packer: RTL

- Parametrised successor to the fixed eight-lane compress/merge tree.
- Accepts a group of NUM_LANES compressed words (data plus 2-bit tag) per handshake and packs the group into a self-describing bitstream: tag header first, then variable-length payloads.
- Emits fixed OUT_WIDTH beats under valid/ready backpressure, with an explicit flush that pads and marks the final beat.
- Sits between the per-lane compress units and the memory/DMA write path.

---
 rtl/compress_stream_packer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/compress_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : compress_stream_packer
// Purpose  : Packs groups of NUM_LANES compressed words (data + 2-bit tag)
//            into a self-describing bitstream. Each group starts with a
//            header made of all lane tags, followed by the variable-length
//            payloads. The stream is emitted as fixed OUT_WIDTH beats under
//            valid/ready backpressure. A flush pads the tail with zeros and
//            marks the final beat.
// Ports    : clk, reset (async active-low)
//            in_valid/in_ready/in_data/in_tag : group input handshake
//            flush                            : terminate current stream
//            out_valid/out_ready/out_data/out_last : beat output handshake
//            flush_done                       : one-cycle flush completion
//            stream_bits                      : bits accepted this stream
// Revision : 1.0 - initial release
// ============================================================================
module compress_stream_packer #(
    parameter int NUM_LANES    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int TAG_WIDTH    = 2,
    parameter int OUT_WIDTH    = 256,
    parameter int BITCNT_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH*NUM_LANES-1:0] in_data,
    input  logic [TAG_WIDTH*NUM_LANES-1:0]  in_tag,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic                            out_last,
    output logic                            flush_done,
    output logic [BITCNT_WIDTH-1:0]         stream_bits
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int c_HDR_BITS = NUM_LANES * TAG_WIDTH;
    localparam int c_MAXG     = NUM_LANES * (TAG_WIDTH + DATA_WIDTH);
    // A group is only accepted while fill < OUT_WIDTH, so the highest bit a
    // group can reach is OUT_WIDTH-1+MAXG-1.
    localparam int c_ACC_W    = OUT_WIDTH - 1 + c_MAXG;
    localparam int c_FILL_W   = $clog2(OUT_WIDTH + c_MAXG) + 1;

    localparam logic [c_FILL_W-1:0]   c_OUT_FILL = c_FILL_W'(OUT_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_MASK_Q   = DATA_WIDTH'({(DATA_WIDTH/4){1'b1}});
    localparam logic [DATA_WIDTH-1:0] c_MASK_H   = DATA_WIDTH'({(DATA_WIDTH/2){1'b1}});
    localparam logic [DATA_WIDTH-1:0] c_MASK_F   = {DATA_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Tag decode helpers
    // ------------------------------------------------------------------------
    function automatic logic [c_FILL_W-1:0] tag_len(input logic [TAG_WIDTH-1:0] tag);
        logic [c_FILL_W-1:0] len;
        len = '0;
        case (tag)
            TAG_WIDTH'(1): len = c_FILL_W'(DATA_WIDTH / 4);
            TAG_WIDTH'(2): len = c_FILL_W'(DATA_WIDTH / 2);
            TAG_WIDTH'(3): len = c_FILL_W'(DATA_WIDTH);
            default:       len = '0;
        endcase
        return len;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] tag_mask(input logic [TAG_WIDTH-1:0] tag);
        logic [DATA_WIDTH-1:0] mask;
        mask = '0;
        case (tag)
            TAG_WIDTH'(1): mask = c_MASK_Q;
            TAG_WIDTH'(2): mask = c_MASK_H;
            TAG_WIDTH'(3): mask = c_MASK_F;
            default:       mask = '0;
        endcase
        return mask;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [c_ACC_W-1:0]      acc_q, acc_d;
    logic [c_FILL_W-1:0]     fill_q, fill_d;
    logic [BITCNT_WIDTH-1:0] bits_q, bits_d;
    // Holds in_ready low until the first clock edge after reset release.
    logic                    en_q;

    // ------------------------------------------------------------------------
    // Group assembly: header of all tags, then payloads tightly packed in
    // lane order. Payload bits above the tag-selected length are masked off.
    // ------------------------------------------------------------------------
    logic [c_MAXG-1:0]     w_group_bits;
    logic [c_FILL_W-1:0]   w_group_len;
    logic [c_FILL_W-1:0]   w_off;
    logic [TAG_WIDTH-1:0]  w_lane_tag;
    logic [DATA_WIDTH-1:0] w_lane_data;

    always_comb begin
        w_group_bits = c_MAXG'(in_tag);
        w_off        = c_FILL_W'(c_HDR_BITS);
        w_lane_tag   = '0;
        w_lane_data  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_lane_tag   = in_tag[i*TAG_WIDTH +: TAG_WIDTH];
            w_lane_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH] & tag_mask(w_lane_tag);
            w_group_bits = w_group_bits | (c_MAXG'(w_lane_data) << w_off);
            w_off        = w_off + tag_len(w_lane_tag);
        end
        w_group_len = w_off;
    end

    // ------------------------------------------------------------------------
    // Control FSM (next state and handshake outputs)
    // ------------------------------------------------------------------------
    logic w_accept;
    logic w_out_fire;

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                in_ready  = en_q && (fill_q < c_OUT_FILL);
                out_valid = (fill_q >= c_OUT_FILL);
                if (flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                out_valid = (fill_q != '0);
                out_last  = out_valid && (fill_q <= c_OUT_FILL);
                // An empty stream has nothing to emit and completes at once.
                if (fill_q == '0) begin
                    state_d = ST_DONE;
                end else if (out_last && out_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                flush_done = 1'b1;
                state_d    = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // ------------------------------------------------------------------------
    // Datapath next state. Accept and beat output never coincide: accept
    // needs fill < OUT_WIDTH while a RUN beat needs fill >= OUT_WIDTH, and
    // nothing is accepted outside RUN.
    // ------------------------------------------------------------------------
    always_comb begin
        acc_d  = acc_q;
        fill_d = fill_q;
        bits_d = bits_q;
        if (w_accept) begin
            // acc is zero above fill, so OR-ing in the shifted group is safe.
            acc_d  = acc_q | (c_ACC_W'(w_group_bits) << fill_q);
            fill_d = fill_q + w_group_len;
            bits_d = bits_q + BITCNT_WIDTH'(w_group_len);
        end else if (w_out_fire) begin
            acc_d  = acc_q >> OUT_WIDTH;
            fill_d = (fill_q > c_OUT_FILL) ? (fill_q - c_OUT_FILL) : '0;
        end
        if (state_q == ST_DONE) begin
            bits_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            acc_q   <= '0;
            fill_q  <= '0;
            bits_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            bits_q  <= bits_d;
            en_q    <= 1'b1;
        end
    end

    assign out_data    = acc_q[OUT_WIDTH-1:0];
    assign stream_bits = bits_q;

endmodule
`default_nettype wire
